// File: rtl/mult_exec_unit.sv
// Fixed-latency pipelined integer multiplier: RR stage for tag info, then LATENCY-1 multiply stages.
// Entries younger than a flushing branch are dropped as they advance; the output is masked the same way.
module mult_exec_unit #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DWIDTH  = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Iss_Mult,
  input  logic [5:0]        Iss_RdPhyAddrMul,
  input  logic [4:0]        Iss_RobTagMul,
  input  logic              Iss_RegWriteMul,
  input  logic [DWIDTH-1:0] PhyReg_MultRsData,
  input  logic [DWIDTH-1:0] PhyReg_MultRtData,
  input  logic              Cdb_Flush,
  input  logic [4:0]        Rob_TopPtr,
  input  logic [4:0]        Cdb_RobDepth,
  output logic              Mul_Done,
  output logic [DWIDTH-1:0] Mul_Out,
  output logic [5:0]        Mul_RdPhyAddr,
  output logic [4:0]        Mul_RobTag,
  output logic              Mul_RdWrite
);

  localparam int unsigned NumM  = LATENCY - 1;
  localparam int unsigned HalfW = DWIDTH / 2;

  // Stage 0 is RR; stages 1..NumM are the multiply stages, NumM drives the outputs.
  logic [NumM:0] valid_q, valid_d;
  logic [4:0]    tag_q [0:NumM];
  logic [4:0]    tag_d [0:NumM];
  logic [5:0]    rd_q  [0:NumM];
  logic [5:0]    rd_d  [0:NumM];
  logic          we_q  [0:NumM];
  logic          we_d  [0:NumM];

  // 5-bit wrap-around age relative to the ROB head.
  function automatic logic is_younger(input logic [4:0] tag, input logic [4:0] top,
                                      input logic [4:0] depth);
    logic [4:0] age;
    age = tag - top;
    return age > depth;
  endfunction

  always_comb begin
    valid_d[0] = Iss_Mult & ~(Cdb_Flush & is_younger(Iss_RobTagMul, Rob_TopPtr, Cdb_RobDepth));
    tag_d[0]   = Iss_RobTagMul;
    rd_d[0]    = Iss_RdPhyAddrMul;
    we_d[0]    = Iss_RegWriteMul;
    for (int k = 1; k <= NumM; k++) begin
      valid_d[k] = valid_q[k-1] &
                   ~(Cdb_Flush & is_younger(tag_q[k-1], Rob_TopPtr, Cdb_RobDepth));
      tag_d[k]   = tag_q[k-1];
      rd_d[k]    = rd_q[k-1];
      we_d[k]    = we_q[k-1];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q <= '0;
      tag_q   <= '{default: '0};
      rd_q    <= '{default: '0};
      we_q    <= '{default: 1'b0};
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
    end
  end

  // M1 holds two partial products split on the Rt halves; their sum is taken on the way out of M1.
  logic [DWIDTH-1:0] rt_lo, rt_hi;
  logic [DWIDTH-1:0] pp_lo_d, pp_hi_d, pp_lo_q, pp_hi_q;
  logic [DWIDTH-1:0] m1_sum;

  always_comb begin
    rt_lo   = DWIDTH'(PhyReg_MultRtData[HalfW-1:0]);
    rt_hi   = DWIDTH'(PhyReg_MultRtData[DWIDTH-1:HalfW]);
    pp_lo_d = PhyReg_MultRsData * rt_lo;
    pp_hi_d = (PhyReg_MultRsData * rt_hi) << HalfW;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pp_lo_q <= '0;
      pp_hi_q <= '0;
    end else begin
      pp_lo_q <= pp_lo_d;
      pp_hi_q <= pp_hi_d;
    end
  end

  assign m1_sum = pp_lo_q + pp_hi_q;

  generate
    if (NumM == 1) begin : g_short
      assign Mul_Out = m1_sum;
    end else begin : g_long
      logic [DWIDTH-1:0] prod_q [2:NumM];
      logic [DWIDTH-1:0] prod_d [2:NumM];

      always_comb begin
        prod_d[2] = m1_sum;
        for (int k = 3; k <= NumM; k++) begin
          prod_d[k] = prod_q[k-1];
        end
      end

      always_ff @(posedge Clk) begin
        if (Reset) begin
          prod_q <= '{default: '0};
        end else begin
          prod_q <= prod_d;
        end
      end

      assign Mul_Out = prod_q[NumM];
    end
  endgenerate

  assign Mul_Done      = valid_q[NumM] &
                         ~(Cdb_Flush & is_younger(tag_q[NumM], Rob_TopPtr, Cdb_RobDepth));
  assign Mul_RdPhyAddr = rd_q[NumM];
  assign Mul_RobTag    = tag_q[NumM];
  assign Mul_RdWrite   = we_q[NumM];

endmodule
